// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor on refclk: pulses pll_rst, qualifies locked, retries, reports ready/fault.
// Optional loss counter output enabled by defining PLL_LOCK_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer #(
   parameter int unsigned RST_PULSE_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic refclk,
   input  logic rst,
   input  logic locked,
   input  logic force_relock,
   output logic pll_rst,
   output logic ready,
   output logic fault,
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
   output logic [7:0]                       loss_cnt
`else
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
`endif
);

   localparam int unsigned MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned MAX_C  = (MAX_AB > LOCK_STABLE_CYCLES) ?
                                    MAX_AB : LOCK_STABLE_CYCLES;
   localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
   localparam int unsigned RW     = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_READY,
      S_FAULT
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          pll_rst_q, pll_rst_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;
   logic          lk_meta_q, lk_s_q;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
      end else begin
         lk_meta_q <= locked;
         lk_s_q    <= lk_meta_q;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      unique case (state_q)
         S_RESET_PLL: begin
            cnt_d = cnt_q + CW'(1);
            if (force_relock) begin
               cnt_d = '0;
            end else if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
            end
         end
         S_WAIT_LOCK: begin
            cnt_d = cnt_q + CW'(1);
            if (force_relock) begin
               state_d = S_RESET_PLL;
            end else if (lk_s_q) begin
               state_d = S_STABLE;
            end else if (cnt_q == TO_LAST) begin
               if (retry_q == RTY_MAX) begin
                  state_d = S_FAULT;
               end else begin
                  retry_d = retry_q + RW'(1);
                  state_d = S_RESET_PLL;
               end
            end
         end
         S_STABLE: begin
            cnt_d = cnt_q + CW'(1);
            if (force_relock) begin
               state_d = S_RESET_PLL;
            end else if (!lk_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STB_LAST) begin
               state_d = S_READY;
               retry_d = '0;
            end
         end
         S_READY: begin
            if (force_relock || !lk_s_q) begin
               state_d = S_RESET_PLL;
            end
         end
         S_FAULT: begin
            if (force_relock) begin
               state_d = S_RESET_PLL;
               retry_d = '0;
            end
         end
         default: begin
            state_d = S_RESET_PLL;
         end
      endcase
      // counter restarts on every state change
      if (state_d != state_q) begin
         cnt_d = '0;
      end
      pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      ready_d   = (state_d == S_READY);
      fault_d   = (state_d == S_FAULT);
   end

   assign pll_rst   = pll_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
   logic [7:0] loss_q, loss_d;

   always_comb begin
      loss_d = loss_q;
      if (state_q == S_READY && !lk_s_q && loss_q != 8'hFF) begin
         loss_d = loss_q + 8'd1;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         loss_q <= 8'd0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed table-driven bench for pll_lock_sequencer (small parameters).
// Loss counter checks compile in when PLL_LOCK_SEQ_LOSS_CNT_EN is defined.
module tb_pll_lock_sequencer;

   logic       refclk;
   logic       rst;
   logic       locked;
   logic       force_relock;
   logic       pll_rst;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
   logic [7:0] loss_cnt;
`endif

   pll_lock_sequencer #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES (100),
      .LOCK_STABLE_CYCLES  (8),
      .MAX_RETRIES         (2)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .locked       (locked),
      .force_relock (force_relock),
      .pll_rst      (pll_rst),
      .ready        (ready),
      .fault        (fault),
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      .retry_cnt    (retry_cnt),
      .loss_cnt     (loss_cnt)
`else
      .retry_cnt    (retry_cnt)
`endif
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   typedef struct {
      logic       lk;
      logic       fr;
      int         n;
      logic       p;
      logic       r;
      logic       f;
      logic [1:0] rt;
      logic [7:0] ls;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   split;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      else
         n_pass++;
   endtask

   task automatic add(input logic lk, input logic fr, input int n,
                      input logic p, input logic r, input logic f,
                      input logic [1:0] rt, input logic [7:0] ls);
      vec_t t;
      t.lk = lk; t.fr = fr; t.n = n;
      t.p = p; t.r = r; t.f = f; t.rt = rt; t.ls = ls;
      tbl.push_back(t);
   endtask

   task automatic run(input int i);
      vec_t t;
      t = tbl[i];
      locked       = t.lk;
      force_relock = t.fr;
      for (int k = 0; k < t.n; k++) begin
         @(posedge refclk);
         #1;
         force_relock = 1'b0;
      end
      chk($sformatf("vec%0d {prst,rdy,flt,rty}", i),
          {27'd0, pll_rst, ready, fault, retry_cnt},
          {27'd0, t.p, t.r, t.f, t.rt});
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      chk($sformatf("vec%0d loss_cnt", i), {24'd0, loss_cnt}, {24'd0, t.ls});
`endif
   endtask

   initial begin
      rst          = 1'b1;
      locked       = 1'b0;
      force_relock = 1'b0;

      // nominal lock, then lock loss from READY
      add(0,0,3,  1,0,0,0,0);
      add(0,0,1,  0,0,0,0,0);
      add(0,0,9,  0,0,0,0,0);
      add(1,0,10, 0,0,0,0,0);
      add(1,0,1,  0,1,0,0,0);
      add(0,0,2,  0,1,0,0,0);
      add(0,0,1,  1,0,0,0,1);
      add(0,0,3,  1,0,0,0,1);
      add(0,0,1,  0,0,0,0,1);
      // timeouts, retries, fault
      add(0,0,99, 0,0,0,0,1);
      add(0,0,1,  1,0,0,1,1);
      add(0,0,3,  1,0,0,1,1);
      add(0,0,1,  0,0,0,1,1);
      add(0,0,99, 0,0,0,1,1);
      add(0,0,1,  1,0,0,2,1);
      add(0,0,3,  1,0,0,2,1);
      add(0,0,1,  0,0,0,2,1);
      add(0,0,99, 0,0,0,2,1);
      add(0,0,1,  1,0,1,2,1);
      add(0,0,20, 1,0,1,2,1);
      // leave FAULT with force_relock, then lock
      add(0,1,1,  1,0,0,0,1);
      add(0,0,3,  1,0,0,0,1);
      add(0,0,1,  0,0,0,0,1);
      add(1,0,10, 0,0,0,0,1);
      add(1,0,1,  0,1,0,0,1);
      // force from READY with lock held, then glitch in STABLE
      add(1,1,1,  1,0,0,0,1);
      add(1,0,3,  1,0,0,0,1);
      add(1,0,1,  0,0,0,0,1);
      add(1,0,6,  0,0,0,0,1);
      add(0,0,3,  0,0,0,0,1);
      add(1,0,10, 0,0,0,0,1);
      add(1,0,1,  0,1,0,0,1);
      // lk_s low and force_relock on the same READY edge
      add(0,0,2,  0,1,0,0,1);
      add(0,1,1,  1,0,0,0,2);
      add(0,0,3,  1,0,0,0,2);
      add(0,0,1,  0,0,0,0,2);
      // one timeout so retry_cnt is nonzero before async reset
      add(0,0,100,1,0,0,1,2);
      add(0,0,4,  0,0,0,1,2);
      add(0,0,10, 0,0,0,1,2);
      split = tbl.size();
      // restart after async reset
      add(0,0,3,  1,0,0,0,0);
      add(0,0,1,  0,0,0,0,0);
      add(1,0,10, 0,0,0,0,0);
      add(1,0,1,  0,1,0,0,0);

      repeat (3) @(posedge refclk);
      #1;
      chk("reset pll_rst",   {31'd0, pll_rst}, 32'd1);
      chk("reset ready",     {31'd0, ready},   32'd0);
      chk("reset fault",     {31'd0, fault},   32'd0);
      chk("reset retry_cnt", {30'd0, retry_cnt}, 32'd0);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      chk("reset loss_cnt",  {24'd0, loss_cnt}, 32'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < split; i++) run(i);

      // async reset mid WAIT_LOCK, checked between edges
      @(posedge refclk);
      #4;
      chk("pre-rst pll_rst", {31'd0, pll_rst}, 32'd0);
      rst = 1'b1;
      #1;
      chk("async pll_rst",   {31'd0, pll_rst}, 32'd1);
      chk("async ready",     {31'd0, ready},   32'd0);
      chk("async fault",     {31'd0, fault},   32'd0);
      chk("async retry_cnt", {30'd0, retry_cnt}, 32'd0);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      chk("async loss_cnt",  {24'd0, loss_cnt}, 32'd0);
`endif
      @(posedge refclk);
      #1;
      chk("held pll_rst",    {31'd0, pll_rst}, 32'd1);
      rst = 1'b0;

      for (int i = split; i < tbl.size(); i++) run(i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
